// File: rtl/sdram_bist_pkg.sv
// Shared types, constants and helpers for the SDRAM BIST initiator.
// Build option SDRAM_BIST_BYTE_LANE_EN adds the partial-write byte-lane states.
package sdram_bist_pkg;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEADBEEF_PAT = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRwait,
    StDone
`ifdef SDRAM_BIST_BYTE_LANE_EN
    ,
    StPwr,
    StPrd,
    StPwait
`endif
  } state_e;

  // Replace byte lane `lane` of `word` with the same lane of `pat`.
  function automatic logic [31:0] merge_byte_lane(input logic [31:0] word,
                                                  input logic [31:0] pat,
                                                  input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    res[{lane, 3'b000} +: 8] = pat[{lane, 3'b000} +: 8];
    return res;
  endfunction

endpackage

// File: rtl/sdram_ctrl_if.sv
// Request/response interface between an SDRAM requester and sdram_core.
interface sdram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] wr;
  logic                    rd;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    rdy;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   read_data;

  modport ctrl (output addr, wr, rd, write_data, input rdy, rvalid, read_data);
  modport core (input addr, wr, rd, write_data, output rdy, rvalid, read_data);
endinterface

// File: rtl/sdram_bist_lfsr.sv
// 32-bit Galois LFSR with seed load (zero seed forced to 1) and advance enable.
module sdram_bist_lfsr
  import sdram_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        adv,
  output logic [31:0] value
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? 32'd1 : seed;
    end else if (adv) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 32'd1;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/sdram_bist.sv
// SDRAM BIST initiator: pseudo-random write/read-back/compare over sdram_ctrl_if.
// Define SDRAM_BIST_BYTE_LANE_EN to add a single-lane partial write/read per iteration.
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_ITERS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned ERRCNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERRCNT_WIDTH-1:0] err_count,
  sdram_ctrl_if.ctrl              sdram_if
);

  localparam int unsigned StrbW   = DATA_WIDTH / 8;
  localparam int unsigned AddrLsb = $clog2(StrbW);
  localparam int unsigned IterW   = $clog2(NUM_ITERS + 1);
  localparam int unsigned TmrW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'((1 << AddrLsb) - 1);

  state_e                  state_q, state_d;
  logic [IterW-1:0]        iter_q, iter_d;
  logic [TmrW-1:0]         tmr_q, tmr_d;
  logic [ERRCNT_WIDTH-1:0] err_q, err_d;
  logic                    timeout_q, timeout_d;
  logic                    lfsr_load, lfsr_adv;
  logic [31:0]             lfsr;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   exp_word;
  logic                    cmp_en, iter_end;

  sdram_bist_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .adv  (lfsr_adv),
    .value(lfsr)
  );

  assign req_addr = lfsr[ADDR_WIDTH-1:0] & AddrMask;

  always_comb begin
    state_d              = state_q;
    iter_d               = iter_q;
    err_d                = err_q;
    timeout_d            = timeout_q;
    lfsr_load            = 1'b0;
    lfsr_adv             = 1'b0;
    cmp_en               = 1'b0;
    iter_end             = 1'b0;
    exp_word             = lfsr[DATA_WIDTH-1:0];
    sdram_if.addr        = '0;
    sdram_if.wr          = '0;
    sdram_if.rd          = 1'b0;
    sdram_if.write_data  = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StWr;
          lfsr_load = 1'b1;
          iter_d    = '0;
          err_d     = '0;
          timeout_d = 1'b0;
        end
      end
      StWr: begin
        sdram_if.addr       = req_addr;
        sdram_if.wr         = '1;
        sdram_if.write_data = lfsr[DATA_WIDTH-1:0];
        if (sdram_if.rdy) state_d = StRd;
      end
      StRd: begin
        sdram_if.addr = req_addr;
        sdram_if.rd   = 1'b1;
        if (sdram_if.rdy) state_d = StRwait;
      end
      StRwait: begin
        if (sdram_if.rvalid) begin
          cmp_en = 1'b1;
`ifdef SDRAM_BIST_BYTE_LANE_EN
          state_d = StPwr;
`else
          iter_end = 1'b1;
`endif
        end
      end
`ifdef SDRAM_BIST_BYTE_LANE_EN
      StPwr: begin
        sdram_if.addr       = req_addr;
        sdram_if.wr         = StrbW'(1) << lfsr[1:0];
        sdram_if.write_data = DATA_WIDTH'(DEADBEEF_PAT);
        if (sdram_if.rdy) state_d = StPrd;
      end
      StPrd: begin
        sdram_if.addr = req_addr;
        sdram_if.rd   = 1'b1;
        if (sdram_if.rdy) state_d = StPwait;
      end
      StPwait: begin
        exp_word = DATA_WIDTH'(merge_byte_lane(lfsr, DEADBEEF_PAT, lfsr[1:0]));
        if (sdram_if.rvalid) begin
          cmp_en   = 1'b1;
          iter_end = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (cmp_en && (sdram_if.read_data != exp_word) && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end

    if (iter_end) begin
      if (iter_q == IterW'(NUM_ITERS - 1)) begin
        state_d = StDone;
      end else begin
        state_d  = StWr;
        iter_d   = iter_q + 1'b1;
        lfsr_adv = 1'b1;
      end
    end

    // A stalled state whose wait budget runs out aborts the run.
    if (busy && (state_d == state_q) && (tmr_q == TmrW'(TIMEOUT_CYCLES - 1))) begin
      state_d   = StDone;
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    tmr_d = '0;
    if (busy && (state_d == state_q)) tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      iter_q    <= '0;
      tmr_q     <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      tmr_q     <= tmr_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_q == '0) && !timeout_q;
  assign timeout   = timeout_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Directed bench for sdram_bist against a latency-configurable memory responder.
module tb_sdram_bist;

  localparam int unsigned NumIters = 10;
`ifdef SDRAM_BIST_BYTE_LANE_EN
  localparam int Step = 2;
`else
  localparam int Step = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;

  sdram_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sdram ();

  sdram_bist #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .NUM_ITERS     (NumIters),
    .TIMEOUT_CYCLES(16),
    .ERRCNT_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .err_count(err_count),
    .sdram_if (sdram)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls and logs
  int          mode = 0;  // 0: rdy after 3 cycles, 1: never rdy, 2: random rdy
  int          flip_at = 0;
  logic        corrupt = 1'b0;
  int          n_wr, n_rd, n_ret;
  int          viol_both, viol_align, viol_stable;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_strb_q[$];
  logic [31:0] rd_ret_q[$];
  logic [31:0] mem[logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    n_wr = 0; n_rd = 0; n_ret = 0;
    viol_both = 0; viol_align = 0; viol_stable = 0;
    wr_addr_q.delete(); wr_data_q.delete(); wr_strb_q.delete(); rd_ret_q.delete();
  endtask

  task automatic pulse_start(input logic [31:0] s);
    seed  = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 3000) begin
      step();
      n++;
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  initial begin : responder
    int          cnt, rd_lat;
    logic [31:0] rd_addr, w, prev_addr, prev_data;
    logic [3:0]  prev_wr;
    logic        prev_rd, prev_pend, req, rdy_n;
    cnt = 0; rd_lat = 0; prev_pend = 1'b0; rd_addr = '0;
    prev_addr = '0; prev_data = '0; prev_wr = '0; prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      sdram.rvalid = 1'b0;
      if (rd_lat > 0) begin
        rd_lat--;
        if (rd_lat == 0) begin
          n_ret++;
          w = mem.exists(rd_addr) ? mem[rd_addr] : 32'd0;
          if (corrupt || n_ret == flip_at) w[0] = ~w[0];
          sdram.rvalid    = 1'b1;
          sdram.read_data = w;
          rd_ret_q.push_back(w);
        end
      end
      req = (sdram.wr != 4'h0) || sdram.rd;
      if (sdram.wr != 4'h0 && sdram.rd) viol_both++;
      if (req && sdram.addr[1:0] != 2'b00) viol_align++;
      if (prev_pend && (sdram.addr != prev_addr || sdram.wr != prev_wr ||
                        sdram.rd != prev_rd || sdram.write_data != prev_data)) viol_stable++;
      cnt = req ? cnt + 1 : 0;
      case (mode)
        0:       rdy_n = req && (cnt >= 3);
        1:       rdy_n = 1'b0;
        default: rdy_n = req && ($urandom_range(0, 3) != 0);
      endcase
      sdram.rdy = rdy_n;
      if (rdy_n) begin
        cnt       = 0;
        prev_pend = 1'b0;
        if (sdram.wr != 4'h0) begin
          w = mem.exists(sdram.addr) ? mem[sdram.addr] : 32'd0;
          for (int i = 0; i < 4; i++) begin
            if (sdram.wr[i]) w[i*8 +: 8] = sdram.write_data[i*8 +: 8];
          end
          mem[sdram.addr] = w;
          n_wr++;
          wr_addr_q.push_back(sdram.addr);
          wr_data_q.push_back(sdram.write_data);
          wr_strb_q.push_back(sdram.wr);
        end else begin
          n_rd++;
          rd_lat  = 4;
          rd_addr = sdram.addr;
        end
      end else begin
        prev_pend = req;
        prev_addr = sdram.addr;
        prev_data = sdram.write_data;
        prev_wr   = sdram.wr;
        prev_rd   = sdram.rd;
      end
    end
  end

  initial begin : main
    int n;
    rst = 1'b1; start = 1'b0; seed = '0;
    sdram.rdy = 1'b0; sdram.rvalid = 1'b0; sdram.read_data = '0;
    clear_logs();
    repeat (3) step();

    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_timeout", 32'(timeout), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_wr", 32'(sdram.wr), 32'd0);
    check_eq("rst_rd", 32'(sdram.rd), 32'd0);
    check_eq("rst_addr", sdram.addr, 32'd0);
    check_eq("rst_wdata", sdram.write_data, 32'd0);
    rst = 1'b0;
    step();

    // Clean run, seed 1, with a start pulse mid-run that must be ignored
    mode = 0;
    clear_logs();
    pulse_start(32'd1);
    repeat (20) step();
    pulse_start(32'd5);
    wait_done("a_done");
    check_eq("a_wr_accepts", 32'(n_wr), 32'(NumIters * Step));
    check_eq("a_rd_accepts", 32'(n_rd), 32'(NumIters * Step));
    check_eq("a_pass", 32'(pass), 32'd1);
    check_eq("a_err", 32'(err_count), 32'd0);
    check_eq("a_timeout", 32'(timeout), 32'd0);
    check_eq("a_wr0_addr", wr_addr_q[0], 32'h0000_0000);
    check_eq("a_wr0_data", wr_data_q[0], 32'h0000_0001);
    check_eq("a_wr0_strb", 32'(wr_strb_q[0]), 32'h0000_000F);
    check_eq("a_wr1_addr", wr_addr_q[Step], 32'h8020_0000);
    check_eq("a_wr1_data", wr_data_q[Step], 32'h8020_0003);
    check_eq("a_wr2_addr", wr_addr_q[2*Step], 32'hC030_0000);
    check_eq("a_wr2_data", wr_data_q[2*Step], 32'hC030_0002);
`ifdef SDRAM_BIST_BYTE_LANE_EN
    // Third iteration has lfsr[1:0]=2: lane 2 gets 8'hAD
    check_eq("a_pwr_strb", 32'(wr_strb_q[5]), 32'h0000_0004);
    check_eq("a_pwr_data", wr_data_q[5], 32'hDEAD_BEEF);
    check_eq("a_prd_data", rd_ret_q[5], 32'hC0AD_0002);
`endif

    // Bit 0 flipped on the third read return
    clear_logs();
    flip_at = 3;
    pulse_start(32'd1);
    wait_done("b_done");
    flip_at = 0;
    check_eq("b_err", 32'(err_count), 32'd1);
    check_eq("b_pass", 32'(pass), 32'd0);
    check_eq("b_rd_accepts", 32'(n_rd), 32'(NumIters * Step));
    check_eq("b_wr_accepts", 32'(n_wr), 32'(NumIters * Step));

    // rdy never rises: abort 16 cycles after entering WR
    clear_logs();
    mode = 1;
    pulse_start(32'd1);
    repeat (15) step();
    check_eq("c_done_early", 32'(done), 32'd0);
    check_eq("c_wr_held", 32'(sdram.wr), 32'h0000_000F);
    step();
    check_eq("c_done", 32'(done), 32'd1);
    check_eq("c_timeout", 32'(timeout), 32'd1);
    check_eq("c_pass", 32'(pass), 32'd0);
    check_eq("c_wr_low", 32'(sdram.wr), 32'd0);
    repeat (3) step();
    check_eq("c_wr_low_later", 32'(sdram.wr), 32'd0);

    // Random rdy: protocol stability and exclusivity
    clear_logs();
    mode = 2;
    pulse_start(32'd1);
    check_eq("d_timeout_cleared", 32'(timeout), 32'd0);
    wait_done("d_done");
    check_eq("d_pass", 32'(pass), 32'd1);
    check_eq("d_wr_accepts", 32'(n_wr), 32'(NumIters * Step));
    check_eq("d_both", 32'(viol_both), 32'd0);
    check_eq("d_align", 32'(viol_align), 32'd0);
    check_eq("d_stable", 32'(viol_stable), 32'd0);

    // Reset during RWAIT, then a late corrupt rvalid
    clear_logs();
    mode = 0;
    pulse_start(32'd1);
    n = 0;
    while (n_rd < 1 && n < 200) begin
      step();
      n++;
    end
    check_eq("e_rd_accept", 32'(n_rd), 32'd1);
    step();
    check_eq("e_busy_pre", 32'(busy), 32'd1);
    step();
    rst = 1'b1;
    corrupt = 1'b1;
    step();
    rst = 1'b0;
    n = 0;
    while (n_ret < 1 && n < 20) begin
      step();
      n++;
    end
    check_eq("e_late_rvalid", 32'(n_ret), 32'd1);
    step();
    corrupt = 1'b0;
    check_eq("e_busy", 32'(busy), 32'd0);
    check_eq("e_done", 32'(done), 32'd0);
    check_eq("e_err", 32'(err_count), 32'd0);
    check_eq("e_timeout", 32'(timeout), 32'd0);
    check_eq("e_rd", 32'(sdram.rd), 32'd0);
    clear_logs();
    pulse_start(32'd0);
    wait_done("e_done_seed0");
    check_eq("e_pass_seed0", 32'(pass), 32'd1);
    check_eq("e_wr0_addr", wr_addr_q[0], 32'h0000_0000);
    check_eq("e_wr0_data", wr_data_q[0], 32'h0000_0001);
    check_eq("e_wr1_data", wr_data_q[Step], 32'h8020_0003);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_bist.md
Name: sdram_bist

Overview:
- Synthesizable built-in self-test initiator that drives the controller side of sdram_ctrl_if into sdram_core, on the same interface sdram_core already serves.
- Per iteration: writes a pseudo-random word to a pseudo-random word-aligned address, reads it back, compares.
- Reports pass/fail, error count and timeout.
- Sits beside sdram_core on boards; replaces bench-only stimulus for on-hardware memory test.

Parameters:
- ADDR_WIDTH, 32, byte address width of sdram_ctrl_if.
- DATA_WIDTH, 32, data width; byte strobes = DATA_WIDTH/8.
- NUM_ITERS, 1024, write/read iterations per run (>=1).
- TIMEOUT_CYCLES, 4096, max cycles waiting on rdy or rvalid before abort.
- ERRCNT_WIDTH, 16, error counter width.

Ports:
- clk  input  1  system clock, same clock as sdram_ctrl_if.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  one-cycle pulse begins a run; ignored while busy.
- seed  input  32  LFSR seed latched on start; 0 is replaced by 1.
- busy  output  1  run in progress.
- done  output  1  run finished; held until next start.
- pass  output  1  valid when done: err_count==0 and !timeout.
- timeout  output  1  run aborted on TIMEOUT_CYCLES expiry.
- err_count  output  ERRCNT_WIDTH  miscompares, saturating.
- sdram_ctrl_if  interface  -  sdram_ctrl_if, request-driving modport. Driven: addr[ADDR_WIDTH], wr[DATA_WIDTH/8], rd, write_data[DATA_WIDTH]. Sampled: rdy, rvalid, read_data[DATA_WIDTH].

Behaviour:
- Reset: state IDLE. busy, done, pass, timeout, wr, rd = 0. err_count, addr, write_data = 0. LFSR = 1, iteration counter = 0, timeout counter = 0.
- LFSR: 32-bit Galois, taps 0x80200003. Advances once per iteration after compare.
- Address = lfsr[ADDR_WIDTH-1:0] with low log2(DATA_WIDTH/8) bits cleared.
- Write data = lfsr[DATA_WIDTH-1:0].
- Handshake:
  - A request is held stable until accepted.
  - Accepted on the rising edge where the request is asserted and rdy=1.
  - wr or rd deasserts the cycle after acceptance.
  - wr and rd are never both asserted.
- Read data: valid on the single cycle rvalid=1, at any latency after read acceptance.
- IDLE: on start, latch seed, clear err_count, timeout and done, set busy → WR.
- WR: wr='1, addr and write_data driven. Accept → RD.
- RD: rd=1, same addr. Accept → RWAIT.
- RWAIT: rd=0. On rvalid, compare read_data to the expected word; mismatch increments err_count (saturates at all-ones).
  - If iteration == NUM_ITERS-1 → DONE.
  - Otherwise iteration+1, LFSR advance → WR.
- Timeout counter: cleared on every state entry; increments in WR/RD/RWAIT. Reaching TIMEOUT_CYCLES sets timeout=1, drops wr/rd → DONE.
- DONE: busy=0, done=1, pass computed. start → re-run as from IDLE.
- start while busy: ignored.
- rvalid outside RWAIT: ignored, no count.
- rst mid-run: all state returns to reset values on the next edge. An outstanding read whose rvalid arrives after reset is ignored.

Optional Feature:
- Macro: SDRAM_BIST_BYTE_LANE_EN.
- Defined:
  - After each full-word read-back, one extra partial write and one extra read are issued (PWR, PRD states, then PWAIT).
  - Partial write: write_data=32'hDEADBEEF, wr = 1 << lfsr[1:0] (single byte lane).
  - Expected read: the previous word with the selected byte replaced by the DEADBEEF byte.
  - Miscompares count into err_count.
  - Iteration advance moves to PWAIT.
- Undefined: wr is always all-ones or zero, and the PWR/PRD/PWAIT states are absent.

Decomposition:
- sdram_bist_pkg holds: state enum, LFSR_TAPS constant, DEADBEEF pattern constant, and a function that merges a byte lane into a word.
- One natural sub-module: sdram_bist_lfsr (seed load, advance enable, 32-bit output).
- The FSM stays in sdram_bist.

Test Plan:
- Fixed-latency responder model: rdy=1 after 3 cycles, rvalid 4 cycles after read accept, correct memory; seed=1, NUM_ITERS=10 → exactly 10 write and 10 read accepts, done=1, pass=1, err_count=0.
- Same model with bit 0 of read_data flipped on the 3rd read → err_count=1, pass=0, all 10 iterations still completed.
- Responder holds rdy=0 forever, TIMEOUT_CYCLES=16 → timeout=1, done=1, pass=0 at 16 cycles after WR entry; wr low afterwards.
- Protocol check: rdy toggling randomly → addr, write_data and wr stay stable while unaccepted; wr&&rd never both high; addr low 2 bits always 0.
- rst asserted while in RWAIT, then a late rvalid with bad data → outputs at reset values; err_count stays 0; a subsequent start with seed=0 behaves as seed=1.
- With SDRAM_BIST_BYTE_LANE_EN, lfsr[1:0]=2 → partial write carries wr=4'b0100; read-back expected {old[31:24],8'hAD,old[15:0]} → pass=1.
